// File: rtl/ddr_channel_arbiter_n_pkg.sv
// Shared types for the DDR channel arbiter: FSM states, arbitration modes
// and the owner-index width helper.
package mem_arb_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    function automatic int owner_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ddr_channel_arbiter_n_rr_arbiter.sv
// Combinational grant picker: fixed priority (ch0 first) or round-robin
// starting at ptr_i and wrapping to channel 0.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_CH   = 3,
    parameter int ARB_MODE = ARB_RR,
    localparam int OW      = owner_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [OW-1:0]     ptr_i,
    output logic [NUM_CH-1:0] gnt_o,
    output logic [OW-1:0]     idx_o,
    output logic              any_o
);

    always_comb begin
        int c;
        c     = 0;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            c = (ARB_MODE == ARB_RR) ? int'(ptr_i) + i : i;
            if (c >= NUM_CH) c = c - NUM_CH;
            if (!any_o && req_i[c]) begin
                any_o    = 1'b1;
                gnt_o[c] = 1'b1;
                idx_o    = OW'(c);
            end
        end
    end

endmodule

// File: rtl/ddr_channel_arbiter_n.sv
// N-channel arbiter in front of a single DDR port; owns the port for one
// transaction at a time and routes completion and read data to the owner.
module ddr_channel_arbiter_n
    import mem_arb_pkg::*;
#(
    parameter int                NUM_CH        = 3,
    parameter int                IDX_W         = 19,
    parameter int                DATA_W        = 64,
    parameter int                BURST_W       = 512,
    parameter int                ARB_MODE      = ARB_RR,
    parameter logic [NUM_CH-1:0] CH_BURST_MASK = 'b001
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        ch_index_valid,
    input  logic [NUM_CH*IDX_W-1:0]  ch_index,
    input  logic [NUM_CH-1:0]        ch_write_enable,
    input  logic [NUM_CH*DATA_W-1:0] ch_write_mask,
    input  logic [NUM_CH*DATA_W-1:0] ch_write_data,
    output logic [NUM_CH-1:0]        ch_index_ready,
    output logic [NUM_CH-1:0]        ch_operation_done,
    output logic [BURST_W-1:0]       ch_read_data,
    output logic                     ddr_chip_enable,
    output logic [IDX_W-1:0]         ddr_index,
    output logic                     ddr_write_enable,
    output logic                     ddr_burst_mode,
    output logic [DATA_W-1:0]        ddr_write_mask,
    output logic [DATA_W-1:0]        ddr_write_data,
    input  logic [BURST_W-1:0]       ddr_read_data,
    input  logic                     ddr_operation_done,
    input  logic                     ddr_ready
);

    localparam int OW = owner_w(NUM_CH);

    arb_state_e          state_q, state_d;
    logic [OW-1:0]       ptr_q, ptr_d;
    logic [OW-1:0]       owner_q, owner_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                we_q, we_d;
    logic                burst_q, burst_d;
    logic [DATA_W-1:0]   mask_q, mask_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [BURST_W-1:0]  rdata_q, rdata_d;
    logic                ce_q, ce_d;
    logic [NUM_CH-1:0]   done_q, done_d;

    logic [NUM_CH-1:0]   gnt;
    logic [OW-1:0]       gidx;
    logic                any_req;
    logic                accept;

    rr_arbiter #(
        .NUM_CH   (NUM_CH),
        .ARB_MODE (ARB_MODE)
    ) u_arb (
        .req_i (ch_index_valid),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gidx),
        .any_o (any_req)
    );

    // The accept strobe is the only combinational output.
    assign accept         = (state_q == IDLE) && any_req && ddr_ready && !reset;
    assign ch_index_ready = accept ? gnt : '0;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        idx_d   = idx_q;
        we_d    = we_q;
        burst_d = burst_q;
        mask_d  = mask_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ce_d    = 1'b0;
        done_d  = '0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    owner_d = gidx;
                    idx_d   = ch_index[int'(gidx)*IDX_W +: IDX_W];
                    mask_d  = ch_write_mask[int'(gidx)*DATA_W +: DATA_W];
                    wdata_d = ch_write_data[int'(gidx)*DATA_W +: DATA_W];
                    burst_d = CH_BURST_MASK[gidx];
                    we_d    = ch_write_enable[gidx] & ~CH_BURST_MASK[gidx];
                    ce_d    = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (ddr_operation_done) begin
                    rdata_d         = ddr_read_data;
                    done_d[owner_q] = 1'b1;
                    state_d         = RESP;
                end
            end
            RESP: begin
                ptr_d   = (owner_q == OW'(NUM_CH-1)) ? '0 : owner_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            burst_q <= 1'b0;
            mask_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ce_q    <= 1'b0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            burst_q <= burst_d;
            mask_q  <= mask_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ce_q    <= ce_d;
            done_q  <= done_d;
        end
    end

    assign ch_operation_done = done_q;
    assign ch_read_data      = rdata_q;
    assign ddr_chip_enable   = ce_q;
    assign ddr_index         = idx_q;
    assign ddr_write_enable  = we_q;
    assign ddr_burst_mode    = burst_q;
    assign ddr_write_mask    = mask_q;
    assign ddr_write_data    = wdata_q;

endmodule

// File: tb/tb_ddr_channel_arbiter_n.sv
// Directed bench: one round-robin and one fixed-priority arbiter share
// the same requester and DDR stimulus.
module tb_ddr_channel_arbiter_n;

    localparam int N  = 3;
    localparam int IW = 19;
    localparam int DW = 64;
    localparam int BW = 512;

    logic            clock = 1'b0;
    logic            reset;
    logic [N-1:0]    ch_index_valid;
    logic [N*IW-1:0] ch_index;
    logic [N-1:0]    ch_write_enable;
    logic [N*DW-1:0] ch_write_mask;
    logic [N*DW-1:0] ch_write_data;
    logic [BW-1:0]   ddr_read_data;
    logic            ddr_operation_done;
    logic            ddr_ready;

    logic [N-1:0]    r_ready, r_done, f_ready, f_done;
    logic [BW-1:0]   r_rdata, f_rdata;
    logic            r_ce, r_we, r_burst, f_ce, f_we, f_burst;
    logic [IW-1:0]   r_idx, f_idx;
    logic [DW-1:0]   r_mask, r_wdata, f_mask, f_wdata;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [DW-1:0] W1 = 64'hDEAD_BEEF_0123_4567;
    localparam logic [BW-1:0] BPAT = {
        64'h8888_7777_6666_5555, 64'h4444_3333_2222_1111,
        64'hFEDC_BA98_7654_3210, 64'h0F1E_2D3C_4B5A_6978,
        64'hCAFE_F00D_1357_9BDF, 64'h2468_ACE0_1122_3344,
        64'hA5A5_5A5A_C3C3_3C3C, 64'h0123_4567_89AB_CDEF};
    localparam logic [DW-1:0] M2 = 64'h00FF_F00F_0F0F_A55A;
    localparam logic [DW-1:0] D2 = 64'h1357_2468_9BDF_ACE0;

    always #5 clock = ~clock;

    ddr_channel_arbiter_n #(.ARB_MODE(1)) dut_rr (
        .clock              (clock),
        .reset              (reset),
        .ch_index_valid     (ch_index_valid),
        .ch_index           (ch_index),
        .ch_write_enable    (ch_write_enable),
        .ch_write_mask      (ch_write_mask),
        .ch_write_data      (ch_write_data),
        .ch_index_ready     (r_ready),
        .ch_operation_done  (r_done),
        .ch_read_data       (r_rdata),
        .ddr_chip_enable    (r_ce),
        .ddr_index          (r_idx),
        .ddr_write_enable   (r_we),
        .ddr_burst_mode     (r_burst),
        .ddr_write_mask     (r_mask),
        .ddr_write_data     (r_wdata),
        .ddr_read_data      (ddr_read_data),
        .ddr_operation_done (ddr_operation_done),
        .ddr_ready          (ddr_ready)
    );

    ddr_channel_arbiter_n #(.ARB_MODE(0)) dut_fx (
        .clock              (clock),
        .reset              (reset),
        .ch_index_valid     (ch_index_valid),
        .ch_index           (ch_index),
        .ch_write_enable    (ch_write_enable),
        .ch_write_mask      (ch_write_mask),
        .ch_write_data      (ch_write_data),
        .ch_index_ready     (f_ready),
        .ch_operation_done  (f_done),
        .ch_read_data       (f_rdata),
        .ddr_chip_enable    (f_ce),
        .ddr_index          (f_idx),
        .ddr_write_enable   (f_we),
        .ddr_burst_mode     (f_burst),
        .ddr_write_mask     (f_mask),
        .ddr_write_data     (f_wdata),
        .ddr_read_data      (ddr_read_data),
        .ddr_operation_done (ddr_operation_done),
        .ddr_ready          (ddr_ready)
    );

    task automatic check(input string tag, input logic [BW-1:0] got,
                         input logic [BW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    logic [N-1:0] rr_exp [5];

    initial begin
        rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
        reset              = 1'b1;
        ch_index_valid     = '0;
        ch_write_enable    = '0;
        ch_index           = {19'h3_0003, 19'h2_0002, 19'h1_0001};
        ch_write_mask      = {M2, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222};
        ch_write_data      = {D2, 64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
        ddr_read_data      = '0;
        ddr_operation_done = 1'b0;
        ddr_ready          = 1'b1;

        // power-on reset state
        tick();
        tick();
        check("rst_ce", BW'(r_ce), BW'(0));
        check("rst_done", BW'(r_done), BW'(0));
        check("rst_ready", BW'(r_ready), BW'(0));
        check("rst_idx", BW'(r_idx), BW'(0));
        check("rst_rdata", r_rdata, '0);
        reset = 1'b0;
        tick();

        // single ch1 word read, done 5 cycles after issue
        ch_index[1*IW +: IW] = 19'h1234;
        ch_write_enable      = 3'b000;
        ch_index_valid       = 3'b010;
        #1;
        check("t2_ready", BW'(r_ready), BW'(3'b010));
        tick();
        ch_index_valid = '0;
        check("t2_ce", BW'(r_ce), BW'(1));
        check("t2_idx", BW'(r_idx), BW'(19'h1234));
        check("t2_burst", BW'(r_burst), BW'(0));
        check("t2_we", BW'(r_we), BW'(0));
        tick();
        check("t2_ce_once", BW'(r_ce), BW'(0));
        for (int i = 0; i < 4; i++) tick();
        check("t2_no_early_done", BW'(r_done), BW'(0));
        ddr_operation_done = 1'b1;
        ddr_read_data      = {448'h0, W1};
        tick();
        ddr_operation_done = 1'b0;
        ddr_read_data      = '0;
        check("t2_done", BW'(r_done), BW'(3'b010));
        check("t2_rdata", BW'(r_rdata[63:0]), BW'(W1));
        tick();
        check("t2_done_pulse", BW'(r_done), BW'(0));
        check("t2_rdata_hold", BW'(r_rdata[63:0]), BW'(W1));

        // ch0 is a burst channel: write request becomes a burst read
        ch_write_enable = 3'b001;
        ch_index_valid  = 3'b001;
        #1;
        check("t3_ready", BW'(r_ready), BW'(3'b001));
        tick();
        ch_index_valid  = '0;
        ch_write_enable = '0;
        check("t3_ce", BW'(r_ce), BW'(1));
        check("t3_we", BW'(r_we), BW'(0));
        check("t3_burst", BW'(r_burst), BW'(1));
        check("t3_idx", BW'(r_idx), BW'(19'h1_0001));
        tick();
        ddr_operation_done = 1'b1;
        ddr_read_data      = BPAT;
        tick();
        ddr_operation_done = 1'b0;
        ddr_read_data      = '0;
        check("t3_done", BW'(r_done), BW'(3'b001));
        check("t3_rdata", r_rdata, BPAT);
        tick();

        // reset while a ch1 read is outstanding in WAIT
        ch_index[1*IW +: IW] = 19'h5_A5A5;
        ch_index_valid       = 3'b010;
        tick();
        ch_index_valid = '0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t1_ce", BW'(r_ce), BW'(0));
        check("t1_done", BW'(r_done), BW'(0));
        check("t1_idx", BW'(r_idx), BW'(0));
        check("t1_rdata", r_rdata, '0);
        check("t1_burst", BW'(r_burst), BW'(0));
        ddr_operation_done = 1'b1;
        ddr_read_data      = BPAT;
        tick();
        ddr_operation_done = 1'b0;
        ddr_read_data      = '0;
        check("t1_stale_done", BW'(r_done), BW'(0));
        tick();
        check("t1_stale_done2", BW'(r_done), BW'(0));
        check("t1_stale_rdata", r_rdata, '0);

        // ch2 store held off by ddr_ready
        ddr_ready       = 1'b0;
        ch_write_enable = 3'b100;
        ch_index_valid  = 3'b100;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("t5_hold_ready", BW'(r_ready), BW'(0));
            check("t5_hold_ce", BW'(r_ce), BW'(0));
            tick();
        end
        ddr_ready = 1'b1;
        #1;
        check("t5_ready", BW'(r_ready), BW'(3'b100));
        tick();
        ch_index_valid  = '0;
        ch_write_enable = '0;
        check("t5_ce", BW'(r_ce), BW'(1));
        check("t5_we", BW'(r_we), BW'(1));
        check("t5_burst", BW'(r_burst), BW'(0));
        check("t5_mask", BW'(r_mask), BW'(M2));
        check("t5_data", BW'(r_wdata), BW'(D2));
        check("t5_idx", BW'(r_idx), BW'(19'h3_0003));
        tick();
        ddr_operation_done = 1'b1;
        tick();
        ddr_operation_done = 1'b0;
        check("t5_done", BW'(r_done), BW'(3'b100));
        tick();

        // done during ISSUE is ignored; only the WAIT done completes
        ch_index_valid = 3'b010;
        tick();
        ch_index_valid     = '0;
        ddr_operation_done = 1'b1;
        tick();
        ddr_operation_done = 1'b0;
        check("t6_issue_done_ign", BW'(r_done), BW'(0));
        tick();
        check("t6_no_done_yet", BW'(r_done), BW'(0));
        ddr_operation_done = 1'b1;
        ddr_read_data      = {448'h0, W1};
        tick();
        ddr_operation_done = 1'b0;
        ddr_read_data      = '0;
        check("t6_done", BW'(r_done), BW'(3'b010));
        tick();
        check("t6_single_pulse", BW'(r_done), BW'(0));

        // all channels valid continuously: rr vs fixed grant order
        reset = 1'b1;
        tick();
        reset          = 1'b0;
        ch_index_valid = 3'b111;
        for (int t = 0; t < 5; t++) begin
            #1;
            check("t4_rr_grant", BW'(r_ready), BW'(rr_exp[t]));
            check("t4_fx_grant", BW'(f_ready), BW'(3'b001));
            tick();
            tick();
            ddr_operation_done = 1'b1;
            tick();
            ddr_operation_done = 1'b0;
            check("t4_rr_done", BW'(r_done), BW'(rr_exp[t]));
            check("t4_fx_done", BW'(f_done), BW'(3'b001));
            tick();
        end
        ch_index_valid = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
